// File: rtl/sigdel_mc.sv
// Multi-channel sigma-delta DAC modulator. Each channel runs in first- or second-order mode.
// Samples are double-buffered (shadow -> active) and a shared prescaler sets the update rate.
module sigdel_mc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DIV_W    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DIV_W-1:0]    div,
  input  logic [CHANNELS-1:0] mode,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [WIDTH-1:0]    in_data,
  output logic [CHANNELS-1:0] out,
  output logic                tick
);

  // The integrators are WIDTH+4 bits wide. The sums use two extra bits of headroom,
  // so saturation can be detected before the result is truncated.
  localparam int IW = WIDTH + 4;
  localparam int EW = WIDTH + 6;
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-IW+1){1'b1}}, {(IW-1){1'b0}}};
  localparam logic signed [EW-1:0] F_EXT   = {{(EW-WIDTH-1){1'b0}}, 1'b1, {WIDTH{1'b0}}};

  function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > SAT_MAX)
      sat = SAT_MAX[IW-1:0];
    else if (v < SAT_MIN)
      sat = SAT_MIN[IW-1:0];
    else
      sat = v[IW-1:0];
  endfunction

  logic [DIV_W-1:0] cnt_reg;
  logic             upd;

  assign upd = en && (cnt_reg >= div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (!en) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else begin
      cnt_reg <= upd ? '0 : cnt_reg + 1'b1;
      tick    <= upd;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0]     shadow_reg;
    logic [WIDTH-1:0]     active_reg;
    logic [WIDTH-1:0]     acc_reg;
    logic signed [IW-1:0] i1_reg;
    logic signed [IW-1:0] i2_reg;
    logic                 mode_prev_reg;
    logic                 y_reg;

    logic [WIDTH:0]       fo_sum;
    logic signed [EW-1:0] x_ext;
    logic signed [EW-1:0] fb_ext;
    logic signed [EW-1:0] i1_sum;
    logic signed [EW-1:0] i2_sum;
    logic signed [IW-1:0] i1_next;
    logic signed [IW-1:0] i2_next;
    logic                 so_bit;

    always_comb begin
      fo_sum  = {1'b0, acc_reg} + {1'b0, active_reg};
      x_ext   = {{(EW-WIDTH){1'b0}}, active_reg};
      fb_ext  = y_reg ? F_EXT : '0;
      i1_sum  = {{(EW-IW){i1_reg[IW-1]}}, i1_reg} + x_ext - fb_ext;
      i1_next = sat(i1_sum);
      // The second stage integrates the already-saturated first-stage value.
      i2_sum  = {{(EW-IW){i2_reg[IW-1]}}, i2_reg} + {{(EW-IW){i1_next[IW-1]}}, i1_next} - fb_ext;
      i2_next = sat(i2_sum);
      so_bit  = !i2_next[IW-1] && (i2_next != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_reg    <= '0;
        active_reg    <= '0;
        acc_reg       <= '0;
        i1_reg        <= '0;
        i2_reg        <= '0;
        mode_prev_reg <= 1'b0;
        y_reg         <= 1'b0;
      end else begin
        if (in_valid && (in_ch == CH_W'(gi)))
          shadow_reg <= in_data;
        if (!en) begin
          acc_reg <= '0;
          i1_reg  <= '0;
          i2_reg  <= '0;
          y_reg   <= 1'b0;
        end else if (upd) begin
          active_reg    <= shadow_reg;
          mode_prev_reg <= mode[gi];
          if (mode[gi] != mode_prev_reg) begin
            acc_reg <= '0;
            i1_reg  <= '0;
            i2_reg  <= '0;
            y_reg   <= 1'b0;
          end else if (mode[gi]) begin
            i1_reg <= i1_next;
            i2_reg <= i2_next;
            y_reg  <= so_bit;
          end else begin
            acc_reg <= fo_sum[WIDTH-1:0];
            y_reg   <= fo_sum[WIDTH];
          end
        end
      end
    end

    assign out[gi] = y_reg;
  end

endmodule

// File: doc/sigdel_mc.md
# sigdel_mc

Parametrised multi-channel sigma-delta modulator, successor to the single-channel 8-bit `sigdel`. It converts CHANNELS unsigned WIDTH-bit samples into 1-bit pulse-density streams on dedicated output pins, for off-chip RC filtering as audio/DC DACs. Per channel, a runtime mode selects first- or second-order noise shaping. A shared prescaler sets the modulator rate. Samples are double-buffered so updates never glitch a running stream.

## Interface
- WIDTH, 8, sample width; full scale F = 2^WIDTH
- CHANNELS, 2, number of independent modulators (1..8)
- DIV_W, 8, prescaler divide-value width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable
- div  in  DIV_W  tick period minus one (tick every div+1 cycles)
- mode  in  CHANNELS  per channel: 0 = first order, 1 = second order
- in_valid  in  1  sample write strobe
- in_ch  in  max(1,clog2(CHANNELS))  target channel of write
- in_data  in  WIDTH  unsigned sample
- out  out  CHANNELS  bitstreams, registered
- tick  out  1  one-cycle pulse, high in each cycle where out holds freshly updated bits

## Operation
- **Prescaler:** counter cnt (DIV_W bits).
  - While en=1, each cycle evaluates upd = (cnt >= div).
  - upd=1: cnt <= 0. Otherwise cnt <= cnt+1.
  - Lowering div mid-count takes effect immediately: a count at or above the new div fires upd.
- **Write path:**
  - in_valid=1 with in_ch < CHANNELS: shadow[in_ch] <= in_data.
  - in_ch >= CHANNELS: write ignored.
  - in_valid is accepted every cycle; there is no backpressure.
- **Update, on each edge where upd=1, per channel c:**
  - active[c] <= shadow[c], as registered before this edge.
  - A write coinciding with upd lands in shadow and becomes active at the next update.
  - The modulator consumes the old active[c]. New samples therefore reach the modulator two updates after the write.
- **First order (mode=0):**
  - sum = acc + x, computed WIDTH+1 bits wide.
  - out[c] <= sum[WIDTH]; acc <= sum[WIDTH-1:0].
  - Long-run density = x/F.
- **Second order (mode=1):**
  - Two signed integrators, each WIDTH+4 bits. y is the current out[c]; fb = y ? F : 0.
  - i1' = i1 + x − fb.
  - i2' = i2 + i1' − fb.
  - out[c] <= (i2' > 0).
  - i1 and i2 saturate at the signed range limits and never wrap.
  - x = 0 yields a constant 0 stream.
- **Mode change:** at each update, the mode[c] sampled that cycle is compared with the mode used at the previous update.
  - On a difference, all state of channel c (acc, i1, i2) is cleared, and out[c] <= 0 for that update.
  - Normal operation in the new mode starts at the next update.
- **en=0:**
  - cnt, acc, i1, i2, out and tick are cleared synchronously and held at 0.
  - Shadow registers keep accepting writes.
  - active registers and the stored previous mode are kept.
  - On re-enable, the first update occurs when cnt reaches div.
- **Reset (rst_n low, asynchronous):** out=0, tick=0, cnt=0, all shadow/active/acc/i1/i2=0, stored mode=0.

## Timing
- tick <= upd (registered). tick and new out values appear on the same edge.
- Output bit rate is clk/(div+1). With div=0, tick stays high continuously while en=1.
- Write-to-stream latency: next update edge loads active; the first output bit using the new sample appears at the following update.
- Reset asserted mid-stream clears the outputs immediately, without waiting for a clock edge.
- After rst_n deasserts with en=1 and div=0:
  - The first update happens on the first clk edge.
  - tick goes high after that edge.
  - The first bits are computed from active=0, so all out bits are 0.

## Test plan
- **First-order density:** WIDTH=8, div=0, mode=0, ch0 ← 64, ch1 ← 192. Over 256 consecutive ticks after settling, ch0 has exactly 64 ones, ch1 has exactly 192, with the pattern period 4 (1000… / 1110…).
- **Second-order density:**
  - mode=1, ch0 ← 128: ones count in any 256-tick window is 128±2.
  - ch0 ← 0: out stays 0.
  - ch0 ← 255: ones count ≥ 250/256 and integrators never wrap (checked against a saturating reference model).
- **Prescaler:**
  - div=3: tick is high exactly one cycle in four, and out changes only on edges where tick rises.
  - Changing div from 9 to 2 while cnt=5 fires an update on the next edge.
- **Write timing:**
  - A write coincident with upd is not used by that update; it is loaded into active at the next update, and affects out one update later.
  - A write with in_ch ≥ CHANNELS (CHANNELS=3, in_ch=3) changes nothing.
- **Mode switch and en:**
  - Toggling mode[1] mid-stream forces out[1]=0 at that update with the state cleared; ch0 is unaffected.
  - en low for 5 cycles zeroes out and tick; shadow writes made during that time take effect after re-enable.
- **Async reset:** assert rst_n low between clock edges mid-stream. out and tick go 0 immediately. After release, the bitstreams restart from zero state.
